uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte-write interface (write strobe, 8-bit data, TXRDY status) among NUM_REQ independent requesters.
- Round-robin arbitration with packet locking: a requester keeps the grant from its first byte until the byte flagged last, so multi-byte messages are never interleaved.
- Sits between firmware/command sources and the UART core. Drives the UART's WEN/DATA_IN and paces writes on its TXRDY.
- Works with the UART built with or without its TX FIFO.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- TIMEOUT_CYC, 1024, cycles a locked owner may leave req_valid low before the lock is broken; legal range 2..65535.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the final byte of the requester's packet.
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot.
- TXRDY  in  1  UART ready to accept a byte (high = ready).
- WEN  out  1  one-cycle write strobe to the UART, active high.
- DATA_OUT  out  8  byte to the UART; valid while WEN is high.
- grant_id  out  clog2(NUM_REQ)  index of current or last owner.
- locked  out  1  packet lock held.
- timeout_err  out  1  one-cycle pulse when a lock is broken by timeout.

Behaviour:
- Reset (async assert, sync release): state=IDLE, WEN=0, DATA_OUT=0, req_ready=0, grant_id=0, locked=0, timeout_err=0, rr pointer=0, timeout counter=0.
- All outputs are registered.
- FSM states: IDLE, OWN, LOAD, ACK, DRAIN.
- IDLE:
  - Transition taken when TXRDY=1 and any req_valid=1.
  - Winner = first asserted req_valid searching upward (mod NUM_REQ) from the rr pointer.
  - Capture req_data[winner] into DATA_OUT, set grant_id=winner, set locked=~req_last[winner], go to LOAD.
- OWN (locked):
  - If req_valid[grant_id]=1 and TXRDY=1: capture the byte, set locked=~req_last[grant_id], go to LOAD. Timeout counter is cleared.
  - Else if req_valid[grant_id]=0: increment the timeout counter.
  - When the counter reaches TIMEOUT_CYC-1 with valid still low: pulse timeout_err, clear locked, go to IDLE.
  - Other requesters are ignored while in OWN.
  - If owner valid and timeout expiry occur in the same cycle, valid wins.
  - If owner valid=1 but TXRDY=0, the counter does not increment.
- LOAD: WEN=1 and req_ready[grant_id]=1 for exactly this one cycle; go to ACK.
  - Requester must hold valid/data/last stable until it sees req_ready.
  - Latency: sample edge -> WEN/req_ready high in the next cycle.
- ACK: wait for TXRDY=0, at most 2 cycles.
  - If seen, go to DRAIN.
  - If not seen after 2 cycles (FIFO not full), go straight to the post-byte decision.
- DRAIN: wait for TXRDY=1, then apply the post-byte decision. No timeout applies while in DRAIN.
- Post-byte decision:
  - locked=1 -> OWN.
  - locked=0 -> IDLE, with rr pointer = (grant_id+1) mod NUM_REQ.
- rr pointer updates only on packet completion or timeout (to grant_id+1), never mid-packet.
- Minimum byte period: 4 cycles (FIFO mode, TXRDY stays high).
- WEN is never asserted while TXRDY was sampled low at the capture edge.
- Single-byte packets (last=1 on first byte) never enter OWN.
- TXRDY low in IDLE: no grant; requests wait, with no starvation.
- Reset mid-packet: lock dropped; any in-flight WEN is cancelled at once.
- grant_id/DATA_OUT hold their last value outside LOAD.

Test Plan:
- Single byte: req_valid[2]=1, data=0xA5, last=1, TXRDY=1 from IDLE -> WEN and req_ready=4'b0100 one cycle later with DATA_OUT=0xA5; locked stays 0; returns to IDLE; rr pointer=3.
- Fairness: all four requesters continuously valid with single-byte packets, rr starting at 0 -> grant order 0,1,2,3,0; no requester serviced twice before the others.
- Packet lock: req1 sends 3 bytes (0x11,0x22,0x33; last on 0x33) while req0/req2 stay valid -> three consecutive WENs with grant_id=1 and locked=1 until the 0x33 WEN; next grant goes to 2.
- Timeout: with TIMEOUT_CYC=8, req3 sends a non-last byte then drops valid -> timeout_err pulses exactly 8 cycles after OWN entry; locked=0; the pending req0 is granted next.
- TXRDY pacing: TXRDY drops 1 cycle after WEN and returns 100 cycles later -> no WEN during low TXRDY; next WEN 1 cycle after the OWN/IDLE capture. FIFO mode (TXRDY constant 1) -> one byte every 4 cycles.
- Reset mid-packet: assert RESET_N=0 while in ACK with locked=1 -> all outputs 0 immediately; after release, the first grant follows the rr pointer=0 ordering.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte-write handshake bundle between NUM_REQ requesters, the arbiter and the UART TX port.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 TXRDY;
  logic                 WEN;
  logic [7:0]           DATA_OUT;
  logic [ID_W-1:0]      grant_id;
  logic                 locked;
  logic                 timeout_err;

  modport slave (
    input  req_valid, req_data, req_last, TXRDY,
    output req_ready, WEN, DATA_OUT, grant_id, locked, timeout_err
  );

  modport master (
    output req_valid, req_data, req_last, TXRDY,
    input  req_ready, WEN, DATA_OUT, grant_id, locked, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte port among NUM_REQ requesters,
// holding the grant for a whole packet and breaking a stalled lock after TIMEOUT_CYC.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic              CLK,
  input logic              RESET_N,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_OWN, S_LOAD, S_ACK, S_DRAIN} state_e;

  state_e               state_q, state_d;
  logic                 wen_q, wen_d;
  logic [7:0]           data_q, data_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [ID_W-1:0]      rr_q, rr_d;
  logic                 locked_q, locked_d;
  logic                 tout_q, tout_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ack_cnt_q, ack_cnt_d;

  logic                 win_found_c;
  logic [ID_W-1:0]      win_id_c;
  logic                 capture_c;
  logic [ID_W-1:0]      cap_id_c;
  logic                 byte_done_c;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // First valid requester searching upward from the round-robin pointer
  always_comb begin
    win_found_c = 1'b0;
    win_id_c    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!win_found_c && bus.req_valid[wrap_add(rr_q, k)]) begin
        win_found_c = 1'b1;
        win_id_c    = wrap_add(rr_q, k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wen_d       = 1'b0;
    data_d      = data_q;
    ready_d     = '0;
    grant_d     = grant_q;
    rr_d        = rr_q;
    locked_d    = locked_q;
    tout_d      = 1'b0;
    cnt_d       = cnt_q;
    ack_cnt_d   = ack_cnt_q;
    capture_c   = 1'b0;
    cap_id_c    = grant_q;
    byte_done_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.TXRDY && win_found_c) begin
          capture_c = 1'b1;
          cap_id_c  = win_id_c;
        end
      end
      S_OWN: begin
        // Owner data beats an expiring timeout in the same cycle
        if (bus.req_valid[grant_q] && bus.TXRDY) begin
          capture_c = 1'b1;
        end else if (!bus.req_valid[grant_q]) begin
          if (cnt_q == TOUT_LAST) begin
            tout_d   = 1'b1;
            locked_d = 1'b0;
            rr_d     = wrap_add(grant_q, 32'd1);
            cnt_d    = '0;
            state_d  = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LOAD: begin
        ack_cnt_d = 1'b0;
        state_d   = S_ACK;
      end
      S_ACK: begin
        // A UART with a non-full FIFO may never drop TXRDY; give up after two cycles
        if (!bus.TXRDY) begin
          state_d = S_DRAIN;
        end else if (ack_cnt_q) begin
          byte_done_c = 1'b1;
        end else begin
          ack_cnt_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (bus.TXRDY) byte_done_c = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (capture_c) begin
      data_d   = bus.req_data[32'(cap_id_c)*8 +: 8];
      grant_d  = cap_id_c;
      locked_d = ~bus.req_last[cap_id_c];
      wen_d    = 1'b1;
      ready_d  = NUM_REQ'(1) << cap_id_c;
      cnt_d    = '0;
      state_d  = S_LOAD;
    end

    if (byte_done_c) begin
      if (locked_q) begin
        state_d = S_OWN;
      end else begin
        state_d = S_IDLE;
        rr_d    = wrap_add(grant_q, 32'd1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      wen_q     <= 1'b0;
      data_q    <= '0;
      ready_q   <= '0;
      grant_q   <= '0;
      rr_q      <= '0;
      locked_q  <= 1'b0;
      tout_q    <= 1'b0;
      cnt_q     <= '0;
      ack_cnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wen_q     <= wen_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      locked_q  <= locked_d;
      tout_q    <= tout_d;
      cnt_q     <= cnt_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

  assign bus.WEN         = wen_q;
  assign bus.DATA_OUT    = data_q;
  assign bus.req_ready   = ready_q;
  assign bus.grant_id    = grant_q;
  assign bus.locked      = locked_q;
  assign bus.timeout_err = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requester models feed bytes, and a
// scoreboard of expected (owner, byte, lock) tuples is checked at every WEN.
module tb_uart_tx_arbiter;
  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned TIMEOUT_CYC = 8;
  localparam int          DEPTH       = 16;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       locked;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET_N;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  logic [8:0]  rq_mem [NUM_REQ][DEPTH];
  int          rq_head [NUM_REQ];
  int          rq_tail [NUM_REQ];
  exp_t        exp_q [$];
  int unsigned wen_cyc_q [$];
  int unsigned tout_cyc_q [$];
  logic        tout_locked;
  logic        txrdy_s;
  exp_t        mon_e;

  always @(posedge CLK) begin
    cyc     <= cyc + 1;
    txrdy_s <= bus.TXRDY;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    logic [8:0] e;
    for (int i = 0; i < NUM_REQ; i++) begin
      e = rq_mem[i][rq_head[i] % DEPTH];
      bus.req_valid[i]       = (rq_head[i] != rq_tail[i]);
      bus.req_data[8*i +: 8] = e[7:0];
      bus.req_last[i]        = e[8];
    end
  endtask

  task automatic send(input int r, input logic [7:0] d, input logic last);
    rq_mem[r][rq_tail[r] % DEPTH] = {last, d};
    rq_tail[r]++;
    drive_reqs();
  endtask

  task automatic expect_byte(input int id, input logic [7:0] d, input logic lk);
    exp_t e;
    e.id = 2'(id); e.data = d; e.locked = lk;
    exp_q.push_back(e);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
      for (int j = 0; j < DEPTH; j++) rq_mem[i][j] = '0;
    end
    exp_q.delete();
    drive_reqs();
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    clear_reqs();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    repeat (6) @(negedge CLK);
  endtask

  task automatic wait_wen(input string tag, output int unsigned w);
    int n;
    n = 0;
    while (bus.WEN !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(bus.WEN), 32'd1);
    w = cyc;
  endtask

  // Requester models and scoreboard checker, all on the falling edge
  initial forever begin
    @(negedge CLK);
    if (RESET_N === 1'b1 && bus.WEN === 1'b1) begin
      wen_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("wen_without_expected_byte", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wen_grant_id", 32'(bus.grant_id), 32'(mon_e.id));
        chk("wen_data_out", 32'(bus.DATA_OUT), 32'(mon_e.data));
        chk("wen_locked", 32'(bus.locked), 32'(mon_e.locked));
        chk("wen_req_ready", 32'(bus.req_ready), 32'(4'(1) << mon_e.id));
        chk("wen_txrdy_at_capture", 32'(txrdy_s), 32'd1);
      end
    end
    if (bus.timeout_err === 1'b1) begin
      tout_cyc_q.push_back(cyc);
      tout_locked = bus.locked;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_ready[i] === 1'b1 && rq_head[i] != rq_tail[i]) rq_head[i]++;
    end
    drive_reqs();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0, w;
    RESET_N   = 1'b0;
    bus.TXRDY = 1'b1;
    clear_reqs();
    repeat (3) @(negedge CLK);
    chk("reset_wen", 32'(bus.WEN), 32'd0);
    chk("reset_data_out", 32'(bus.DATA_OUT), 32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_grant_id", 32'(bus.grant_id), 32'd0);
    chk("reset_locked", 32'(bus.locked), 32'd0);
    chk("reset_timeout_err", 32'(bus.timeout_err), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Single-byte packet from requester 2: WEN one cycle after the capture edge
    wen_cyc_q.delete();
    c0 = cyc;
    send(2, 8'hA5, 1'b1);
    expect_byte(2, 8'hA5, 1'b0);
    wait_done("t1_done", 20);
    chk("t1_latency", wen_cyc_q[0], c0 + 1);
    chk("t1_locked_after", 32'(bus.locked), 32'd0);

    // Pointer is now 3: requester 3 beats requester 0
    send(0, 8'h01, 1'b1);
    send(3, 8'h03, 1'b1);
    expect_byte(3, 8'h03, 1'b0);
    expect_byte(0, 8'h01, 1'b0);
    wait_done("t1_rr3_done", 30);

    // Fairness from pointer 0 with everyone continuously valid, FIFO-mode pacing
    do_reset();
    wen_cyc_q.delete();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 4; i++) begin
        send(i, 8'(16*i + j), 1'b1);
        expect_byte(i, 8'(16*i + j), 1'b0);
      end
    wait_done("t2_done", 80);
    chk("t2_wen_count", 32'(wen_cyc_q.size()), 32'd8);
    for (int k = 1; k < 8; k++) chk("t2_fifo_period", wen_cyc_q[k] - wen_cyc_q[k-1], 32'd4);

    // Packet lock: requester 1 sends three bytes while 0 and 2 wait
    send(0, 8'h0A, 1'b1);
    expect_byte(0, 8'h0A, 1'b0);
    wait_done("t3_pre_done", 20);
    wen_cyc_q.delete();
    send(1, 8'h11, 1'b0);
    send(1, 8'h22, 1'b0);
    send(1, 8'h33, 1'b1);
    send(0, 8'h0B, 1'b1);
    send(2, 8'h2C, 1'b1);
    expect_byte(1, 8'h11, 1'b1);
    expect_byte(1, 8'h22, 1'b1);
    expect_byte(1, 8'h33, 1'b0);
    expect_byte(2, 8'h2C, 1'b0);
    expect_byte(0, 8'h0B, 1'b0);
    wait_done("t3_done", 60);
    chk("t3_packet_period", wen_cyc_q[1] - wen_cyc_q[0], 32'd4);

    // Timeout: requester 3 stalls mid-packet, pending requester 0 follows
    wen_cyc_q.delete();
    tout_cyc_q.delete();
    send(3, 8'h3C, 1'b0);
    send(0, 8'h0D, 1'b1);
    expect_byte(3, 8'h3C, 1'b1);
    expect_byte(0, 8'h0D, 1'b0);
    wait_done("t4_done", 60);
    chk("t4_timeout_pulses", 32'(tout_cyc_q.size()), 32'd1);
    chk("t4_timeout_cycle", tout_cyc_q[0], wen_cyc_q[0] + 3 + TIMEOUT_CYC);
    chk("t4_timeout_unlocks", 32'(tout_locked), 32'd0);
    chk("t4_next_grant_cycle", wen_cyc_q[1], wen_cyc_q[0] + 4 + TIMEOUT_CYC);

    // TXRDY pacing: UART without FIFO holds TXRDY low for 100 cycles
    wen_cyc_q.delete();
    tout_cyc_q.delete();
    send(1, 8'h51, 1'b0);
    send(1, 8'h52, 1'b1);
    expect_byte(1, 8'h51, 1'b1);
    expect_byte(1, 8'h52, 1'b0);
    wait_wen("t5_first_wen", w);
    @(negedge CLK);
    bus.TXRDY = 1'b0;
    repeat (100) @(negedge CLK);
    bus.TXRDY = 1'b1;
    wait_done("t5_done", 20);
    chk("t5_wen_count", 32'(wen_cyc_q.size()), 32'd2);
    chk("t5_second_wen_cycle", wen_cyc_q[1], w + 103);
    chk("t5_no_timeout", 32'(tout_cyc_q.size()), 32'd0);

    // TXRDY low in IDLE: request waits, then is granted the cycle after TXRDY returns
    wen_cyc_q.delete();
    bus.TXRDY = 1'b0;
    send(2, 8'h62, 1'b1);
    expect_byte(2, 8'h62, 1'b0);
    repeat (10) @(negedge CLK);
    chk("t6_no_wen_while_low", 32'(wen_cyc_q.size()), 32'd0);
    c0 = cyc;
    bus.TXRDY = 1'b1;
    wait_done("t6_done", 20);
    chk("t6_grant_after_txrdy", wen_cyc_q[0], c0 + 1);

    // Reset in ACK while locked, then arbitration restarts from pointer 0
    send(1, 8'h71, 1'b0);
    send(1, 8'h72, 1'b0);
    send(1, 8'h73, 1'b1);
    expect_byte(1, 8'h71, 1'b1);
    wait_wen("t7_first_wen", w);
    @(negedge CLK);
    chk("t7_locked_in_ack", 32'(bus.locked), 32'd1);
    RESET_N = 1'b0;
    clear_reqs();
    #1;
    chk("t7_reset_wen", 32'(bus.WEN), 32'd0);
    chk("t7_reset_data_out", 32'(bus.DATA_OUT), 32'd0);
    chk("t7_reset_grant_id", 32'(bus.grant_id), 32'd0);
    chk("t7_reset_locked", 32'(bus.locked), 32'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    send(3, 8'h83, 1'b1);
    send(1, 8'h81, 1'b1);
    expect_byte(1, 8'h81, 1'b0);
    expect_byte(3, 8'h83, 1'b0);
    wait_done("t7_done", 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
